// File: rtl/cpc_sdram_arbiter.sv
// SDRAM command-port arbiter: ROM download bytes vs. CPU ram port, switched per clkref slot.
// Optional ARB_STATS_EN adds dl_count/dl_drop download statistics outputs.
module cpc_sdram_arbiter #(
  parameter int PAGE_BITS = 14,
  parameter int ADDR_W    = 23,
  parameter int MAX_PAGE  = 5
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_ref,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_din,
  input  logic [1:0]        cpu_bank,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_bank,
  output logic [7:0]        mem_din,
  output logic              cpu_hold
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       dl_count,
  output logic [7:0]        dl_drop
`endif
);

  // state  | meaning
  // IDLE   | no byte pending, dl_wait low
  // ARM    | byte latched, waiting for the next slot
  // COMMIT | mem_we driven for one full slot
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int HI_W = ADDR_W - PAGE_BITS;
  localparam int PG_W = 25 - PAGE_BITS;

  logic [1:0]        state;
  logic              dl_own;
  logic              own_next;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_bank;
  logic [7:0]        lat_data;

  logic [PG_W-1:0]   page;
  logic              page_ok;
  logic [HI_W-1:0]   page_hi;
  logic              page_bank;

  always_comb begin
    page      = dl_addr[24:PAGE_BITS];
    page_ok   = (page <= PG_W'(MAX_PAGE));
    page_bank = (page >= PG_W'(3));
    page_hi   = HI_W'(263);
    case (page)
      PG_W'(0), PG_W'(3): page_hi = HI_W'(0);
      PG_W'(1), PG_W'(4): page_hi = HI_W'(256);
      default:            page_hi = HI_W'(263);
    endcase
  end

  // Ownership is only re-evaluated on a slot boundary so no slot is split.
  assign own_next = ce_ref ? (dl_active || (state != S_IDLE)) : dl_own;
  assign cpu_hold = dl_own;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      dl_own   <= 1'b0;
      dl_wait  <= 1'b0;
      lat_addr <= '0;
      lat_bank <= 1'b0;
      lat_data <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_bank <= '0;
      mem_din  <= '0;
    end else begin
      case (state)
        S_IDLE: if (dl_wr && page_ok) begin
          lat_addr <= {page_hi, dl_addr[PAGE_BITS-1:0]};
          lat_bank <= page_bank;
          lat_data <= dl_data;
          dl_wait  <= 1'b1;
          state    <= S_ARM;
        end
        S_ARM: if (ce_ref) state <= S_COMMIT;
        S_COMMIT: if (ce_ref) begin
          dl_wait <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      dl_own <= own_next;

      if (own_next) begin
        mem_oe <= 1'b0;
        mem_we <= ((state == S_ARM) && ce_ref) || ((state == S_COMMIT) && !ce_ref);
        if ((state == S_ARM) && ce_ref) begin
          mem_addr <= lat_addr;
          mem_bank <= {1'b0, lat_bank};
          mem_din  <= lat_data;
        end
      end else begin
        mem_oe   <= cpu_r && !cpu_w;
        mem_we   <= cpu_w;
        mem_addr <= cpu_a;
        mem_bank <= cpu_bank;
        mem_din  <= cpu_din;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic dl_active_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      dl_count    <= '0;
      dl_drop     <= '0;
    end else begin
      dl_active_q <= dl_active;
      if (dl_active && !dl_active_q) begin
        dl_count <= '0;
        dl_drop  <= '0;
      end else begin
        if ((state == S_COMMIT) && ce_ref && (dl_count != 16'hFFFF))
          dl_count <= dl_count + 16'd1;
        if ((state == S_IDLE) && dl_wr && !page_ok && (dl_drop != 8'hFF))
          dl_drop <= dl_drop + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpc_sdram_arbiter.sv
// Directed bench for cpc_sdram_arbiter; ce_ref is generated as one pulse every 16 clocks.
module tb_cpc_sdram_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_ref;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        cpu_r;
  logic        cpu_w;
  logic [22:0] cpu_a;
  logic [7:0]  cpu_din;
  logic [1:0]  cpu_bank;
  logic        mem_oe;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        cpu_hold;
`ifdef ARB_STATS_EN
  logic [15:0] dl_count;
  logic [7:0]  dl_drop;
`endif

  int passes = 0;
  int total  = 0;
  int phase  = 0;

  always #5 clk_sys = ~clk_sys;

  cpc_sdram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref), .dl_active(dl_active),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_bank(cpu_bank),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_din(mem_din), .cpu_hold(cpu_hold)
`ifdef ARB_STATS_EN
    , .dl_count(dl_count), .dl_drop(dl_drop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge; afterwards outputs are sampled and ce_ref is set up for the next edge.
  task automatic cyc();
    @(posedge clk_sys);
    @(negedge clk_sys);
    phase = (phase + 1) % 16;
    ce_ref = (phase == 15);
  endtask

  // Advance until the coming edge is a slot edge (bounded).
  task automatic to_ce();
    int n = 0;
    while (!ce_ref && n < 40) begin
      cyc();
      n++;
    end
    if (!ce_ref) chk("ce_bound", {31'd0, ce_ref}, 32'd1);
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    cyc();
    dl_wr = 1'b0;
  endtask

  initial begin
    int saw_we;
    reset = 1'b1; ce_ref = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; cpu_r = 1'b0; cpu_w = 1'b0;
    cpu_a = '0; cpu_din = '0; cpu_bank = '0;
    cyc(); cyc();
    chk("rst_dl_wait", {31'd0, dl_wait}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    reset = 1'b0;
    cyc();

    // CPU path, registered with 1-cycle latency
    cpu_w = 1'b1; cpu_a = 23'h01234; cpu_din = 8'h5A; cpu_bank = 2'd1;
    cyc();
    chk("cpu_w_we", {31'd0, mem_we}, 32'd1);
    chk("cpu_w_addr", {9'd0, mem_addr}, 32'h01234);
    chk("cpu_w_din", {24'd0, mem_din}, 32'h5A);
    chk("cpu_w_bank", {30'd0, mem_bank}, 32'd1);
    chk("cpu_w_hold", {31'd0, cpu_hold}, 32'd0);
    cpu_w = 1'b0; cpu_r = 1'b1; cpu_a = 23'h7ABCD;
    cyc();
    chk("cpu_r_oe", {31'd0, mem_oe}, 32'd1);
    chk("cpu_r_we", {31'd0, mem_we}, 32'd0);
    chk("cpu_r_addr", {9'd0, mem_addr}, 32'h7ABCD);
    cpu_w = 1'b1;
    cyc();
    chk("cpu_rw_oe", {31'd0, mem_oe}, 32'd0);
    chk("cpu_rw_we", {31'd0, mem_we}, 32'd1);
    cpu_w = 1'b0;

    // dl_active rising with cpu_r held: handover only on the slot edge
    to_ce(); cyc();
    dl_active = 1'b1;
    cyc();
    chk("handover_pre_oe", {31'd0, mem_oe}, 32'd1);
    chk("handover_pre_hold", {31'd0, cpu_hold}, 32'd0);
    to_ce(); cyc();
    chk("handover_oe", {31'd0, mem_oe}, 32'd0);
    chk("handover_hold", {31'd0, cpu_hold}, 32'd1);
    cpu_r = 1'b0;

    // Byte 1: page 1, plus an ignored dl_wr while waiting
    dl_byte(25'h0_4123, 8'hA5);
    chk("b1_wait", {31'd0, dl_wait}, 32'd1);
    chk("b1_we_early", {31'd0, mem_we}, 32'd0);
    dl_byte(25'h0_0055, 8'h33);
    to_ce();
    chk("b1_we_pre", {31'd0, mem_we}, 32'd0);
    cyc();
    chk("b1_we", {31'd0, mem_we}, 32'd1);
    chk("b1_addr", {9'd0, mem_addr}, 32'h40_0123);
    chk("b1_bank", {30'd0, mem_bank}, 32'd0);
    chk("b1_din", {24'd0, mem_din}, 32'hA5);
    to_ce();
    chk("b1_we_hold", {31'd0, mem_we}, 32'd1);
    chk("b1_wait_hold", {31'd0, dl_wait}, 32'd1);
    cyc();
    chk("b1_we_end", {31'd0, mem_we}, 32'd0);
    chk("b1_wait_end", {31'd0, dl_wait}, 32'd0);

    // Byte 2: page 5, dl_wr coincident with a slot edge
    to_ce();
    dl_byte(25'h1_4001, 8'h3C);
    chk("b2_wait", {31'd0, dl_wait}, 32'd1);
    to_ce();
    chk("b2_no_commit_yet", {31'd0, mem_we}, 32'd0);
    cyc();
    chk("b2_we", {31'd0, mem_we}, 32'd1);
    chk("b2_addr", {9'd0, mem_addr}, 32'h41_C001);
    chk("b2_bank", {30'd0, mem_bank}, 32'd1);
    to_ce(); cyc();
    chk("b2_wait_end", {31'd0, dl_wait}, 32'd0);

    // Page 6: dropped
    dl_byte(25'h1_8000, 8'hEE);
    saw_we = 0;
    for (int i = 0; i < 20; i++) begin
      if (dl_wait || mem_we) saw_we = 1;
      cyc();
    end
    chk("drop_no_activity", saw_we, 32'd0);
`ifdef ARB_STATS_EN
    chk("drop_count", {24'd0, dl_drop}, 32'd1);
`endif

    // Byte 3: page 0
    dl_byte(25'h0_0010, 8'h11);
    to_ce(); cyc();
    chk("b3_addr", {9'd0, mem_addr}, 32'h00_0010);
    chk("b3_din", {24'd0, mem_din}, 32'h11);
    to_ce(); cyc();
`ifdef ARB_STATS_EN
    chk("dl_count3", {16'd0, dl_count}, 32'd3);
`endif

    // Byte 4: page 3, dl_active falls mid-COMMIT
    dl_byte(25'h0_C002, 8'h44);
    to_ce(); cyc();
    chk("b4_addr", {9'd0, mem_addr}, 32'h00_0002);
    chk("b4_bank", {30'd0, mem_bank}, 32'd1);
    cyc();
    dl_active = 1'b0; cpu_r = 1'b1; cpu_a = 23'h00456;
    to_ce(); cyc();
    chk("b4_we_end", {31'd0, mem_we}, 32'd0);
    chk("b4_hold_kept", {31'd0, cpu_hold}, 32'd1);
    chk("b4_oe_blocked", {31'd0, mem_oe}, 32'd0);
    to_ce(); cyc();
    chk("b4_hold_release", {31'd0, cpu_hold}, 32'd0);
    chk("b4_cpu_oe", {31'd0, mem_oe}, 32'd1);
    chk("b4_cpu_addr", {9'd0, mem_addr}, 32'h00456);
    cpu_r = 1'b0;

    // Reset during COMMIT, then a clean restart
    dl_active = 1'b1;
    dl_byte(25'h0_8000, 8'h77);
    to_ce(); cyc();
    chk("b5_we", {31'd0, mem_we}, 32'd1);
    chk("b5_addr", {9'd0, mem_addr}, 32'h41_C000);
    #1 reset = 1'b1;
    #1;
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_wait", {31'd0, dl_wait}, 32'd0);
    chk("arst_addr", {9'd0, mem_addr}, 32'd0);
    chk("arst_din", {24'd0, mem_din}, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd0);
    cyc();
    reset = 1'b0;
`ifdef ARB_STATS_EN
    chk("arst_count", {16'd0, dl_count}, 32'd0);
`endif
    dl_byte(25'h0_4000, 8'h99);
    chk("b6_wait", {31'd0, dl_wait}, 32'd1);
    to_ce(); cyc();
    chk("b6_we", {31'd0, mem_we}, 32'd1);
    chk("b6_addr", {9'd0, mem_addr}, 32'h40_0000);
    chk("b6_din", {24'd0, mem_din}, 32'h99);
    to_ce(); cyc();
    chk("b6_wait_end", {31'd0, dl_wait}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
